// File: rtl/vga_timing_gen_p_if.sv
// Pixel-side bundle of the raster timing generator: source fetch port plus DAC pins.
// master = generator, slave = frame buffer / DAC side.
interface vga_timing_gen_p_if #(
  parameter int CW = 12
);
  logic [CW-1:0] Din;
  logic          tp_sel;
  logic          pix_req;
  logic [9:0]    x;
  logic [9:0]    y;
  logic [CW-1:0] rgb;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic          frame_start;
  logic          line_start;

  modport master (
    input  Din, tp_sel,
    output pix_req, x, y, rgb, hsync, vsync, de, frame_start, line_start
  );

  modport slave (
    output Din, tp_sel,
    input  pix_req, x, y, rgb, hsync, vsync, de, frame_start, line_start
  );
endinterface

// File: rtl/vga_timing_gen_p.sv
// Parametrised raster timing generator: fetch request at counter+1, pins at counter+RD_LAT+2.
// Optional colour-bar source guarded by VGA_TESTPAT_EN; no backpressure, free-running pixel clock.
module vga_timing_gen_p #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CW       = 12,
  parameter int RD_LAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  vga_timing_gen_p_if.master vif
);
  localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int H_AS  = H_SYNC + H_BP;
  localparam int H_AE  = H_AS + H_ACTIVE;
  localparam int V_AS  = V_SYNC + V_BP;
  localparam int V_AE  = V_AS + V_ACTIVE;
  localparam logic HP  = 1'(H_POL);
  localparam logic VP  = 1'(V_POL);

  if (RD_LAT < 0 || RD_LAT > 4 || H_ACTIVE < 1 || V_ACTIVE < 1 ||
      H_ACTIVE > 1024 || V_ACTIVE > 1024 || CW < 3) begin : g_param_check
    $error("vga_timing_gen_p: parameter out of range");
  end

  // Sync flags hold "inside pulse" so a cleared pipeline means inactive level at the pins.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
    logic ls;
  } stg_t;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [31:0]   hc, vc;
  stg_t          st_d;
  logic [9:0]    x_d, y_d, x_q, y_q;
  stg_t          pipe_q [RD_LAT+1];
  stg_t          out_q;
  logic [CW-1:0] rgb_d, rgb_q;

  assign hc = 32'(hcnt_q);
  assign vc = 32'(vcnt_q);

  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hc == H_TOT - 1) begin
      hcnt_d = '0;
      vcnt_d = (vc == V_TOT - 1) ? '0 : vcnt_q + 1'b1;
    end
  end

  always_comb begin
    st_d    = '0;
    x_d     = '0;
    y_d     = '0;
    st_d.hs = hc < H_SYNC;
    st_d.vs = vc < V_SYNC;
    st_d.de = (hc >= H_AS) && (hc < H_AE) && (vc >= V_AS) && (vc < V_AE);
    st_d.ls = st_d.de && (hc == H_AS);
    st_d.fs = st_d.ls && (vc == V_AS);
    if (st_d.de) begin
      x_d = 10'(hc - 32'(H_AS));
      y_d = 10'(vc - 32'(V_AS));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      for (int i = 0; i <= RD_LAT; i++) pipe_q[i] <= '0;
      out_q  <= '0;
      rgb_q  <= '0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pipe_q[0] <= st_d;
      for (int i = 1; i <= RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      out_q     <= pipe_q[RD_LAT];
      rgb_q     <= rgb_d;
    end
  end

`ifdef VGA_TESTPAT_EN
  // Bar width floors H_ACTIVE/8; bar 7 absorbs the remainder.
  localparam int BW = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [2:0] bar_d;
  logic [2:0] bar_q [RD_LAT+1];

  function automatic logic [CW-1:0] bar_colour(input logic [2:0] b);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < CW / 3; i++) begin
      c[2*(CW/3) + i] = ~b[1];
      c[CW/3 + i]     = ~b[2];
      c[i]            = ~b[0];
    end
    return c;
  endfunction

  always_comb begin
    bar_d = '0;
    for (int k = 1; k < 8; k++) begin
      if (32'(x_d) >= 32'(k * BW)) bar_d = 3'(k);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= RD_LAT; i++) bar_q[i] <= '0;
    end else begin
      bar_q[0] <= bar_d;
      for (int i = 1; i <= RD_LAT; i++) bar_q[i] <= bar_q[i-1];
    end
  end

  always_comb begin
    rgb_d = '0;
    if (pipe_q[RD_LAT].de) rgb_d = vif.tp_sel ? bar_colour(bar_q[RD_LAT]) : vif.Din;
  end
`else
  logic unused_tp;
  assign unused_tp = vif.tp_sel;

  always_comb begin
    rgb_d = '0;
    if (pipe_q[RD_LAT].de) rgb_d = vif.Din;
  end
`endif

  assign vif.pix_req     = pipe_q[0].de;
  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.rgb         = rgb_q;
  assign vif.hsync       = out_q.hs ? HP : ~HP;
  assign vif.vsync       = out_q.vs ? VP : ~VP;
  assign vif.de          = out_q.de;
  assign vif.frame_start = out_q.fs;
  assign vif.line_start  = out_q.ls;
endmodule

// File: tb/tb_vga_timing_gen_p.sv
// Small-mode bench: positional model of the raster, random source data and random mid-frame resets.
module tb_vga_timing_gen_p;
  localparam int H_SYNC = 4, H_BP = 3, H_ACTIVE = 20, H_FP = 2;
  localparam int V_SYNC = 2, V_BP = 2, V_ACTIVE = 6, V_FP = 1;
  localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int FT = H_TOT * V_TOT;
  localparam int CW = 12, RD_LAT = 2, LAT = RD_LAT + 2;
  localparam bit HP = 1'b1, VP = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_p_if #(.CW(CW)) vif ();

  vga_timing_gen_p #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
    .H_POL(1), .V_POL(0), .CW(CW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vif(vif)
  );

  int n_chk = 0, n_fail = 0;
  int m = 0;
  int de_cnt, ls_cnt, fs_cnt, hs_cnt, vs_cnt, first_fs;
  logic [CW-1:0] hist [0:4];
  logic [CW-1:0] bar_tbl [0:7];

  // Clock edges since reset release == position of the DUT's counters.
  always @(posedge clk or negedge rst)
    if (!rst) m <= 0;
    else      m <= m + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at m=%0d: actual=%0h required=%0h", name, m, act, exp);
    end
  endtask

  function automatic void pos_model(input int p, output logic de, output logic hs,
                                    output logic vs, output int xx, output int yy);
    int h, v;
    de = 1'b0; hs = 1'b0; vs = 1'b0; xx = 0; yy = 0;
    if (p >= 0) begin
      h  = p % H_TOT;
      v  = (p / H_TOT) % V_TOT;
      hs = h < H_SYNC;
      vs = v < V_SYNC;
      xx = h - (H_SYNC + H_BP);
      yy = v - (V_SYNC + V_BP);
      de = xx >= 0 && xx < H_ACTIVE && yy >= 0 && yy < V_ACTIVE;
      if (!de) begin xx = 0; yy = 0; end
    end
  endfunction

  function automatic logic [CW-1:0] bar_rgb(input int xx);
    int idx;
    idx = xx / (H_ACTIVE / 8);
    if (idx > 7) idx = 7;
    return bar_tbl[idx];
  endfunction

  function automatic logic tp_eff();
`ifdef VGA_TESTPAT_EN
    return vif.tp_sel;
`else
    return 1'b0;
`endif
  endfunction

  logic de_e, hs_e, vs_e, rq_e, hs_u, vs_u;
  int xx_e, yy_e, xr_e, yr_e;
  logic [CW-1:0] rgb_e, px;

  always @(negedge clk) begin
    pos_model(m - LAT, de_e, hs_e, vs_e, xx_e, yy_e);
    rgb_e = 0;
    if (de_e) begin
      px    = {yy_e[5:0], xx_e[5:0]};
      rgb_e = tp_eff() ? bar_rgb(xx_e) : px;
    end
    check("de", vif.de, de_e);
    check("rgb", vif.rgb, rgb_e);
    check("hsync", vif.hsync, hs_e ? HP : !HP);
    check("vsync", vif.vsync, vs_e ? VP : !VP);
    check("line_start", vif.line_start, de_e && xx_e == 0);
    check("frame_start", vif.frame_start, de_e && xx_e == 0 && yy_e == 0);
    pos_model(m - 1, rq_e, hs_u, vs_u, xr_e, yr_e);
    check("pix_req", vif.pix_req, rq_e);
    check("x", vif.x, xr_e);
    check("y", vif.y, yr_e);

    // Hand-computed pins on line 0: first active pixel reaches the pins at m = 4*29+7+4 = 127.
    if (rst && m == 127) check("pin_x0", vif.rgb, tp_eff() ? 12'hFFF : 12'h000);
    if (rst && m == 129) check("pin_x2", vif.rgb, tp_eff() ? 12'hFF0 : 12'h002);
    if (rst && m == 140) check("pin_x13", vif.rgb, tp_eff() ? 12'h00F : 12'h00D);
    if (rst && m == 146) check("pin_x19", vif.rgb, tp_eff() ? 12'h000 : 12'h013);

    if (!rst) begin
      de_cnt = 0; ls_cnt = 0; fs_cnt = 0; hs_cnt = 0; vs_cnt = 0; first_fs = -1;
    end else if (m >= LAT && m < 2 * FT + LAT) begin
      de_cnt += int'(vif.de);
      ls_cnt += int'(vif.line_start);
      fs_cnt += int'(vif.frame_start);
      hs_cnt += int'(vif.hsync == HP);
      vs_cnt += int'(vif.vsync == VP);
      if (vif.frame_start && first_fs < 0) first_fs = m;
    end

    // Source model: returns {y,x} of a request RD_LAT cycles later, junk otherwise.
    for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = vif.pix_req ? {vif.y[5:0], vif.x[5:0]} : CW'($urandom);
    vif.Din = hist[RD_LAT];
  end

  task automatic check_reset(input string tag);
    check({tag, "_pix_req"}, vif.pix_req, 1'b0);
    check({tag, "_x"}, vif.x, 10'd0);
    check({tag, "_y"}, vif.y, 10'd0);
    check({tag, "_de"}, vif.de, 1'b0);
    check({tag, "_rgb"}, vif.rgb, 12'h000);
    check({tag, "_fs"}, vif.frame_start, 1'b0);
    check({tag, "_ls"}, vif.line_start, 1'b0);
    check({tag, "_hsync"}, vif.hsync, 1'b0);
    check({tag, "_vsync"}, vif.vsync, 1'b1);
  endtask

  initial begin
    bar_tbl[0] = 12'hFFF; bar_tbl[1] = 12'hFF0; bar_tbl[2] = 12'h0FF; bar_tbl[3] = 12'h0F0;
    bar_tbl[4] = 12'hF0F; bar_tbl[5] = 12'hF00; bar_tbl[6] = 12'h00F; bar_tbl[7] = 12'h000;
    for (int i = 0; i < 5; i++) hist[i] = '0;
    vif.tp_sel = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset("por");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int seg = 0; seg < 4; seg++) begin
      repeat (2 * FT + LAT + 1) @(negedge clk);
      #1;
      check("de_per_2frames", de_cnt, 2 * 120);
      check("line_start_per_2frames", ls_cnt, 12);
      check("frame_start_per_2frames", fs_cnt, 2);
      check("hsync_active_clocks", hs_cnt, 2 * 11 * 4);
      check("vsync_active_clocks", vs_cnt, 2 * 2 * 29);
      check("first_frame_start_m", first_fs, 127);
      repeat ($urandom_range(10, 600)) @(negedge clk);
      #2 rst = 1'b0;
      #1 check_reset("midframe");
      vif.tp_sel = (seg % 2 == 0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
    end
    repeat (200) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
